mul_div_unit: RTL and testbench

- Execute-stage HI/LO unit that carries out the multiply/divide commands the instruction decoder emits on mulCtrl/mulEnable/mulOutputSel.
- Runs mult, multu, div, divu, madd, maddu and msub as multi-cycle operations, and mthi/mtlo as single-cycle writes.
- Holds the architectural HI and LO registers and feeds mfhi/mflo results back to the GRF write path.
- Exports a busy flag that the hazard unit uses to stall any later HI/LO instruction.

---
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO unit: multi-cycle multiply/divide/accumulate plus
// single-cycle mthi/mtlo, with a busy flag for the hazard unit.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        outputSel,
  output logic [31:0] out,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic { IDLE, RUN } state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u, acc;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Arithmetic on the latched operands; accumulate ops use HI/LO as held at completion.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    acc    = {hi_q, lo_q};
    if (a_q == 32'h8000_0000 && b_q == '1) begin
      quo_s = 32'h8000_0000;
      rem_s = '0;
    end else begin
      quo_s = $signed(a_q) / $signed(b_q);
      rem_s = $signed(a_q) % $signed(b_q);
    end
    quo_u = a_q / b_q;
    rem_u = a_q % b_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(ctrl))
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB: begin
              op_d    = op_e'(ctrl);
              a_d     = operandA;
              b_d     = operandB;
              cnt_d   = CW'(MUL_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op_e'(ctrl);
              a_d     = operandA;
              b_d     = operandB;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = operandA;
            OP_MTLO: lo_d = operandA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MADD:  {hi_d, lo_d} = acc + prod_s;
            OP_MADDU: {hi_d, lo_d} = acc + prod_u;
            OP_MSUB:  {hi_d, lo_d} = acc - prod_s;
            OP_DIV: begin
              if (b_q != '0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != '0) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    out  = outputSel ? hi_q : lo_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO and busy
// length; a monitor checks on every busy completion or explicit sample request.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] operandA, operandB;
  logic        outputSel;
  logic [31:0] out, hi, lo;
  logic        busy;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl(ctrl),
    .operandA(operandA), .operandB(operandB), .outputSel(outputSel),
    .out(out), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic sample_req = 1'b0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // Monitor: pops on busy falling edge or an explicit sample request.
  initial begin : monitor
    logic prev_busy;
    int   busy_cnt;
    exp_t e;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if ((prev_busy && busy !== 1'b1) || (sample_req && busy !== 1'b1)) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
        end else begin
          e = q.pop_front();
          cmp({e.name, ".hi"}, hi, e.hi);
          cmp({e.name, ".lo"}, lo, e.lo);
          cmp({e.name, ".out"}, out, outputSel ? e.hi : e.lo);
          cmp({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
        end
        busy_cnt = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic expect_res(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = c; e.name = n;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; ctrl = c; operandA = a; operandB = b;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 4'd0;
  endtask

  task automatic sample();
    sample_req = 1'b1;
    @(negedge clk); #1;
    sample_req = 1'b0;
  endtask

  task automatic wait_drain(input string n);
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s.timeout: %0d entries pending, expected 0", n, q.size());
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ctrl = 4'd0;
    operandA = '0; operandB = '0; outputSel = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    expect_res("reset", 32'h0, 32'h0, 0);
    sample(); wait_drain("reset");

    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3); wait_drain("mult");

    outputSel = 1'b0;
    expect_res("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_drain("multu");

    expect_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2); wait_drain("div");

    outputSel = 1'b1;
    expect_res("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd4, 32'd7, 32'd0); wait_drain("divu_by0");

    expect_res("undef_op", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    issue(4'd12, 32'hAAAA_AAAA, 32'h5);
    issue(4'd0, 32'hBBBB_BBBB, 32'h6);
    sample(); wait_drain("undef_op");

    expect_res("mthi", 32'h1234_5678, 32'hFFFF_FFFD, 0);
    issue(4'd5, 32'h1234_5678, 32'h0);
    sample(); wait_drain("mthi");

    expect_res("mtlo", 32'h1234_5678, 32'h0000_0001, 0);
    issue(4'd6, 32'h0000_0001, 32'h0);
    sample(); wait_drain("mtlo");

    expect_res("madd", 32'h1234_5678, 32'h0000_0007, 5);
    issue(4'd7, 32'd2, 32'd3); wait_drain("madd");

    outputSel = 1'b0;
    expect_res("msub", 32'h1234_5677, 32'hFFFF_FFFF, 5);
    issue(4'd9, 32'd1, 32'd8); wait_drain("msub");

    expect_res("maddu", 32'h1234_5679, 32'hFFFF_FFFD, 5);
    issue(4'd8, 32'hFFFF_FFFF, 32'd2); wait_drain("maddu");

    expect_res("div_ovf", 32'h0, 32'h8000_0000, 10);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain("div_ovf");

    // Starts during busy must not restart or disturb the divide.
    outputSel = 1'b1;
    expect_res("busy_ignore", 32'd2, 32'd14, 10);
    issue(4'd4, 32'd100, 32'd7);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd5, 32'hDEAD_BEEF, 32'd0);
    wait_drain("busy_ignore");

    expect_res("reset_abort", 32'h0, 32'h0, 3);
    issue(4'd3, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_drain("reset_abort");

    repeat (15) @(posedge clk);
    #1;
    expect_res("no_late_wb", 32'h0, 32'h0, 0);
    sample(); wait_drain("no_late_wb");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
